// File: rtl/phase_pkg.sv
// Shared types and defaults for the phase counter controller.
// PHASE_CTRL_TIMEOUT_EN adds the FAULT state to the FSM encoding.
package phase_pkg;

    localparam int unsigned DEB_CYCLES_DEF  = 500;
    localparam int unsigned ACK_TIMEOUT_DEF = 16;
    localparam logic [4:0]  PHASE_IDLE      = 5'd0;

    typedef enum logic [2:0] {
        StIdle,
        StStartReq,
        StRun,
        StStopReq
`ifdef PHASE_CTRL_TIMEOUT_EN
        ,
        StFault
`endif
    } phase_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability-window debouncer for one push-button.
// rise pulses for one cycle in the same cycle the debounced level goes high.
module btn_debounce
    import phase_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dout_q, dout_d;
    logic            rise_q, rise_d;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level, so any glitch back to the old value restarts the window.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        rise_d = 1'b0;
        if (sync_q[1] != dout_q) begin
            if (cnt_q == CntLast) begin
                dout_d = sync_q[1];
                rise_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;

endmodule

// File: rtl/phase_ctrl.sv
// Push-button start/stop controller for an external phase counter.
// Define PHASE_CTRL_TIMEOUT_EN to add the acknowledgement timeout and FAULT state.
module phase_ctrl
    import phase_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn,
    input  logic [4:0] q,
    output logic       start,
    output logic       stop,
    output logic       running,
    output logic       fault
);

    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    logic btn_level;
    logic btn_rise;
    logic press;
    logic q_idle;

    phase_state_e state_q, state_d;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .CLK (CLK),
        .RST (RST),
        .din (btn),
        .dout(btn_level),
        .rise(btn_rise)
    );

    assign press  = btn_rise && btn_level;
    assign q_idle = (q == PHASE_IDLE);

`ifdef PHASE_CTRL_TIMEOUT_EN
    localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AckW-1:0] AckMax  = AckW'(ACK_TIMEOUT);
    localparam logic [AckW-1:0] AckLast = AckW'(ACK_TIMEOUT - 1);

    logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
`endif

    // Acknowledgement is checked before press everywhere, so a press that
    // coincides with an ack is simply dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (press) state_d = StStartReq;
            end
            StStartReq: begin
                if (!q_idle) state_d = StRun;
`ifdef PHASE_CTRL_TIMEOUT_EN
                else if (ack_cnt_q == AckLast) state_d = StFault;
`endif
            end
            StRun: begin
                if (q_idle) state_d = StIdle;
                else if (press) state_d = StStopReq;
            end
            StStopReq: begin
                if (q_idle) state_d = StIdle;
`ifdef PHASE_CTRL_TIMEOUT_EN
                else if (ack_cnt_q == AckLast) state_d = StFault;
`endif
            end
`ifdef PHASE_CTRL_TIMEOUT_EN
            StFault: state_d = StFault;
`endif
            default: state_d = StIdle;
        endcase
    end

`ifdef PHASE_CTRL_TIMEOUT_EN
    always_comb begin
        ack_cnt_d = ack_cnt_q;
        if ((state_d != state_q) && ((state_d == StStartReq) || (state_d == StStopReq))) begin
            ack_cnt_d = '0;
        end else if (ack_cnt_q != AckMax) begin
            ack_cnt_d = ack_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
`ifdef PHASE_CTRL_TIMEOUT_EN
            ack_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef PHASE_CTRL_TIMEOUT_EN
            ack_cnt_q <= ack_cnt_d;
`endif
        end
    end

    assign start   = (state_q == StStartReq);
    assign stop    = (state_q == StStopReq);
    assign running = (state_q == StRun);
`ifdef PHASE_CTRL_TIMEOUT_EN
    assign fault   = (state_q == StFault);
`else
    assign fault   = 1'b0;
`endif

endmodule

// File: tb/tb_phase_ctrl.sv
// Self-checking bench for phase_ctrl with DEB_CYCLES=4, ACK_TIMEOUT=16.
// Expected start/stop pulse lengths are queued by each test and popped by the pulse monitor.
module tb_phase_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned ACK = 16;

    typedef struct {
        bit is_stop;
        int len;
    } pulse_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       btn;
    logic [4:0] q;
    logic       start;
    logic       stop;
    logic       running;
    logic       fault;

    pulse_t exp_q[$];
    pulse_t mon_e;
    int     vectors = 0;
    int     errors  = 0;
    int     s_len   = 0;
    int     p_len   = 0;

    phase_ctrl #(
        .DEB_CYCLES (DEB),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .btn    (btn),
        .q      (q),
        .start  (start),
        .stop   (stop),
        .running(running),
        .fault  (fault)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    // Pulse monitor: measures every start/stop pulse and scores it against the queue.
    always @(negedge CLK) begin
        if (start === 1'b1 && stop === 1'b1) begin
            errors++;
            $display("FAIL start_stop_overlap start=%b stop=%b required not both high", start, stop);
        end
        if (start === 1'b1) begin
            s_len++;
        end else if (s_len > 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start_pulse len=%0d required no pulse", s_len);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_stop !== 1'b0 || mon_e.len !== s_len) begin
                    errors++;
                    $display("FAIL start_pulse got start len=%0d required %s len=%0d", s_len,
                             mon_e.is_stop ? "stop" : "start", mon_e.len);
                end
            end
            s_len = 0;
        end
        if (stop === 1'b1) begin
            p_len++;
        end else if (p_len > 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_stop_pulse len=%0d required no pulse", p_len);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_stop !== 1'b1 || mon_e.len !== p_len) begin
                    errors++;
                    $display("FAIL stop_pulse got stop len=%0d required %s len=%0d", p_len,
                             mon_e.is_stop ? "stop" : "start", mon_e.len);
                end
            end
            p_len = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_pulse(input bit is_stop, input int len);
        pulse_t e;
        e.is_stop = is_stop;
        e.len     = len;
        exp_q.push_back(e);
    endtask

    // Releases, lets the debouncer settle low, then presses; returns in the
    // first cycle after the FSM has consumed the press.
    task automatic press();
        btn = 1'b0;
        tick(DEB + 4);
        btn = 1'b1;
        tick(DEB + 3);
        btn = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        btn = 1'b1;
        RST = 1'b1;
        tick(2);
        vectors++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b want=0", start); end
        vectors++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop got=%b want=0", stop); end
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", running); end
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault); end
        expect_pulse(1'b0, 1);
        RST = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (start === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n !== DEB + 3) begin
            errors++;
            $display("FAIL reset_held_btn_press start after %0d cycles want %0d", n, DEB + 3);
        end
        q = 5'd1;
        tick(1);
        vectors++; if (running !== 1'b1) begin errors++; $display("FAIL reset_ack_running got=%b want=1", running); end
        q = 5'd0;
        tick(1);
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL spontaneous_done_running got=%b want=0", running); end
        btn = 1'b0;
        tick(DEB + 4);
    endtask

    task automatic test_bounce();
        int n;
        btn = 1'b0;
        tick(DEB + 4);
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0);
            tick(2);
            vectors++;
            if (start !== 1'b0) begin
                errors++;
                $display("FAIL bounce_no_start seg=%0d got=%b want=0", i, start);
            end
        end
        expect_pulse(1'b0, 1);
        btn = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (start === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n !== DEB + 3) begin
            errors++;
            $display("FAIL bounce_stable_press start after %0d cycles want %0d", n, DEB + 3);
        end
        q = 5'd2;
        tick(1);
        q = 5'd0;
        tick(1);
        btn = 1'b0;
        tick(DEB + 4);
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL bounce_idle_running got=%b want=0", running); end
    endtask

    task automatic test_full_cycle();
        q = 5'd0;
        expect_pulse(1'b0, 3);
        press();
        vectors++; if (start !== 1'b1) begin errors++; $display("FAIL full_start_high got=%b want=1", start); end
        tick(2);
        q = 5'd3;
        tick(1);
        vectors++; if (start !== 1'b0) begin errors++; $display("FAIL full_start_low got=%b want=0", start); end
        vectors++; if (running !== 1'b1) begin errors++; $display("FAIL full_running got=%b want=1", running); end
        expect_pulse(1'b1, 2);
        press();
        vectors++; if (stop !== 1'b1) begin errors++; $display("FAIL full_stop_high got=%b want=1", stop); end
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL full_stopreq_running got=%b want=0", running); end
        tick(1);
        q = 5'd0;
        tick(1);
        vectors++; if (stop !== 1'b0) begin errors++; $display("FAIL full_stop_low got=%b want=0", stop); end
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL full_idle_running got=%b want=0", running); end
    endtask

    task automatic test_ignore_in_req();
        q = 5'd0;
        expect_pulse(1'b0, 16);
        press();
        press();
        vectors++; if (start !== 1'b1) begin errors++; $display("FAIL ignore_start_held got=%b want=1", start); end
        q = 5'd1;
        tick(1);
        vectors++; if (running !== 1'b1) begin errors++; $display("FAIL ignore_ack_running got=%b want=1", running); end
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL ignore_ack_fault got=%b want=0", fault); end
        tick(DEB + 4);
        vectors++; if (stop !== 1'b0) begin errors++; $display("FAIL ignore_no_queue_stop got=%b want=0", stop); end
        q = 5'd0;
        tick(1);
    endtask

    task automatic test_same_cycle();
        q = 5'd0;
        expect_pulse(1'b0, 1);
        press();
        q = 5'd7;
        tick(1);
        vectors++; if (running !== 1'b1) begin errors++; $display("FAIL same_setup_running got=%b want=1", running); end
        btn = 1'b0;
        tick(DEB + 4);
        btn = 1'b1;
        tick(DEB + 2);
        q = 5'd0;
        tick(1);
        btn = 1'b0;
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL same_running got=%b want=0", running); end
        vectors++; if (stop !== 1'b0) begin errors++; $display("FAIL same_stop got=%b want=0", stop); end
        tick(DEB + 4);
        vectors++; if (start !== 1'b0) begin errors++; $display("FAIL same_no_restart got=%b want=0", start); end
    endtask

    task automatic test_reset_mid();
        q = 5'd0;
        expect_pulse(1'b0, 3);
        press();
        tick(2);
        vectors++; if (start !== 1'b1) begin errors++; $display("FAIL mid_start_before got=%b want=1", start); end
        RST = 1'b1;
        tick(1);
        vectors++; if (start !== 1'b0) begin errors++; $display("FAIL mid_start_after got=%b want=0", start); end
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL mid_fault got=%b want=0", fault); end
        RST = 1'b0;
        tick(2);
        vectors++; if (start !== 1'b0) begin errors++; $display("FAIL mid_idle_start got=%b want=0", start); end
    endtask

`ifdef PHASE_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        q = 5'd0;
        expect_pulse(1'b0, ACK);
        press();
        tick(ACK - 1);
        vectors++; if (start !== 1'b1) begin errors++; $display("FAIL timeout_last_start got=%b want=1", start); end
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL timeout_early_fault got=%b want=0", fault); end
        tick(1);
        vectors++; if (start !== 1'b0) begin errors++; $display("FAIL timeout_start got=%b want=0", start); end
        vectors++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_fault got=%b want=1", fault); end
        press();
        q = 5'd1;
        tick(2);
        vectors++; if (start !== 1'b0) begin errors++; $display("FAIL fault_press_start got=%b want=0", start); end
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL fault_running got=%b want=0", running); end
        vectors++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b want=1", fault); end
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        q = 5'd0;
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_reset got=%b want=0", fault); end
    endtask
`endif

    initial begin
        RST = 1'b1;
        btn = 1'b0;
        q   = 5'd0;
        test_reset();
        test_bounce();
        test_full_cycle();
        test_ignore_in_req();
        test_same_cycle();
        test_reset_mid();
`ifdef PHASE_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        tick(5);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pulses_pending got=%0d outstanding want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/phase_ctrl.md
PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 500, giving the debounce stability window in CLK cycles.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 16, giving the maximum cycles a start/stop request waits for acknowledgement.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit, the synchronous active-high reset.
REQ-005 The block SHALL have port btn, input, 1 bit, the raw asynchronous push-button, active-high.
REQ-006 The block SHALL have port q, input, 5 bits, the phase index returned by the phase counter; 5'd0 means idle.
REQ-007 The block SHALL have port start, output, 1 bit, the start request to the phase counter.
REQ-008 The block SHALL have port stop, output, 1 bit, the stop request to the phase counter.
REQ-009 The block SHALL have port running, output, 1 bit, high while the phase counter is acknowledged as active.
REQ-010 The block SHALL have port fault, output, 1 bit, a sticky acknowledgement-timeout flag.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after the synchronized input holds a new value for DEB_CYCLES consecutive cycles.
REQ-012 A debounced rising edge SHALL produce a 1-cycle internal press pulse; the press pulse is 2 + DEB_CYCLES cycles after the first stable btn high.
REQ-013 The FSM SHALL have states IDLE, START_REQ, RUN, STOP_REQ and FAULT.
REQ-014 In IDLE, a press SHALL move the FSM to START_REQ.
REQ-015 In START_REQ, start SHALL be held high; q != 0 SHALL move the FSM to RUN, with start low from the next cycle.
REQ-016 In RUN, running SHALL be high; a press SHALL move the FSM to STOP_REQ.
REQ-017 In RUN, q returning to 0 without a press SHALL move the FSM to IDLE, as a spontaneous completion.
REQ-018 In STOP_REQ, stop SHALL be held high; q == 0 SHALL move the FSM to IDLE.
REQ-019 start and stop SHALL never be high in the same cycle.
REQ-020 A press in START_REQ or STOP_REQ SHALL be ignored, with no queuing.
REQ-021 The acknowledgement counter SHALL be ceil(log2(ACK_TIMEOUT+1)) bits wide, clear on entry to START_REQ or STOP_REQ, and saturate without wrapping.
REQ-022 A press and an acknowledgement in the same cycle SHALL resolve in favour of the acknowledgement; the press is dropped.

Reset
REQ-023 When RST is high at a clock edge, the FSM SHALL go to IDLE; start=0, stop=0, running=0, fault=0; the synchronizer, debounced level and counters SHALL clear to 0.
REQ-024 Reset SHALL take priority over all other events, including mid-request; start and stop SHALL be low in the cycle after RST is sampled high.
REQ-025 After reset, a btn already held high SHALL be treated as a new press once it has been stable for DEB_CYCLES.

Configuration
REQ-026 Macro PHASE_CTRL_TIMEOUT_EN defined: if START_REQ or STOP_REQ lasts ACK_TIMEOUT cycles without acknowledgement, the FSM SHALL enter FAULT, with start=stop=0 and fault=1; FAULT SHALL exit only on RST.
REQ-027 Macro PHASE_CTRL_TIMEOUT_EN not defined: the FSM SHALL wait indefinitely for acknowledgement; the FAULT state and the acknowledgement counter SHALL be absent; fault SHALL be tied to 0.

Structure
REQ-028 Package phase_pkg SHALL hold the FSM state typedef, PHASE_IDLE = 5'd0, and the DEB_CYCLES and ACK_TIMEOUT defaults.
REQ-029 The synchronizer and debouncer SHALL be a single sub-module, btn_debounce (CLK, RST, din, dout, rise), reusable for other buttons.

Verification
REQ-030 Reset check: RST=1 for 2 cycles with btn=1 -> start=stop=running=fault=0; with DEB_CYCLES=4, a press follows 6 cycles after RST falls.
REQ-031 Bounce check: with DEB_CYCLES=4, btn toggles every 2 cycles for 20 cycles, then holds 1 -> no press during the toggling; exactly one start request after 4 stable cycles.
REQ-032 Full cycle: press, then q=5'd3 after 3 cycles -> start is high for exactly 3 cycles, then running=1; second press, then q=0 after 2 cycles -> stop is high for 2 cycles, then IDLE with running=0.
REQ-033 Timeout, with PHASE_CTRL_TIMEOUT_EN and ACK_TIMEOUT=16: press with q held at 0 -> start is high for 16 cycles, then fault=1 and start=0; further presses are ignored until RST.
REQ-034 Same-cycle events: in RUN, q falls to 0 in the same cycle as a press -> IDLE, and stop is never asserted.
REQ-035 Reset mid-request: RST asserted during START_REQ -> start=0 the next cycle, IDLE, fault=0.
